pong_draw_scheduler: RTL and testbench

Arbitrates the single VGA adapter pixel-write port between four draw requesters: screen clear, left paddle, right paddle and ball. Each requester asks for one filled rectangle. The block latches the winner's rectangle and rasterises it at one pixel per clock onto x/y/colour/plot. It also generates the free-running frame tick that the game FSM uses to pace its draw sequence.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_rect_raster.sv | 73 +++++++
 rtl/pong_draw_scheduler.sv | 154 +++++++++++++++
 tb/tb_pong_draw_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pkg: screen geometry, requester indices and scheduler state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
package pong_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam int REQ_CLEAR = 0;
  localparam int REQ_LEFT  = 1;
  localparam int REQ_RIGHT = 2;
  localparam int REQ_BALL  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_FIN  = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/pong_rect_raster.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_rect_raster: row-major cx/cy scan counters and pixel coordinate adders.
// Rev 1.0
// ---------------------------------------------------------------------------
module pong_rect_raster #(
  parameter int X_W = pong_pkg::X_W,
  parameter int Y_W = pong_pkg::Y_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] w_m1_i,
  input  logic [Y_W-1:0] h_m1_i,
  output logic           last_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           on_screen_o
);
  import pong_pkg::*;

  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic [X_W:0]   w_px;
  logic [Y_W:0]   w_py;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step_i) begin
      if (cx_q == w_m1_i) begin
        cx_d = '0;
        cy_d = cy_q + Y_W'(1);
      end else begin
        cx_d = cx_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign last_o = (cx_q == w_m1_i) && (cy_q == h_m1_i);

  // Adders see the next counter values so registered outputs align with the plotted pixel.
  assign w_px = {1'b0, x0_i} + {1'b0, cx_d};
  assign w_py = {1'b0, y0_i} + {1'b0, cy_d};
  assign x_o  = w_px[X_W-1:0];
  assign y_o  = w_py[Y_W-1:0];

`ifdef PONG_CLIP_EN
  assign on_screen_o = (w_px < (X_W+1)'(H_RES)) && (w_py < (Y_W+1)'(V_RES));
`else
  logic w_unused_carry;
  assign w_unused_carry = w_px[X_W] ^ w_py[Y_W];
  assign on_screen_o    = 1'b1;
`endif

endmodule
`default_nettype wire

// File: rtl/pong_draw_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_draw_scheduler: fixed-priority rectangle rasteriser plus frame tick.
// Define PONG_CLIP_EN to suppress plot on pixels outside 160x120. Rev 1.0
// ---------------------------------------------------------------------------
module pong_draw_scheduler #(
  parameter int X_W          = pong_pkg::X_W,
  parameter int Y_W          = pong_pkg::Y_W,
  parameter int COLOUR_W     = pong_pkg::COLOUR_W,
  parameter int FRAME_CYCLES = 833333
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*X_W-1:0]      rect_x,
  input  logic [4*Y_W-1:0]      rect_y,
  input  logic [4*X_W-1:0]      rect_w_m1,
  input  logic [4*Y_W-1:0]      rect_h_m1,
  input  logic [4*COLOUR_W-1:0] rect_colour,
  output logic [3:0]            grant,
  output logic [3:0]            done,
  output logic                  busy,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [COLOUR_W-1:0]   colour_out,
  output logic                  plot,
  output logic                  frame_tick
);
  import pong_pkg::*;

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  sched_state_e         state_q;
  logic [3:0]           grant_q, owner_q;
  logic [X_W-1:0]       x0_q, w_m1_q, x_out_q;
  logic [Y_W-1:0]       y0_q, h_m1_q, y_out_q;
  logic [COLOUR_W-1:0]  colour_out_q;
  logic                 plot_q, tick_q;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;

  logic [1:0]           w_win_idx;
  logic [3:0]           w_win_oh;
  logic                 w_req_any, w_idle, w_last, w_on_screen;
  logic [X_W-1:0]       w_x0, w_w_m1, w_px;
  logic [Y_W-1:0]       w_y0, w_h_m1, w_py;

  always_comb begin
    w_win_idx = 2'd0;
    for (int i = REQ_BALL; i >= REQ_CLEAR; i--) begin
      if (req[i]) w_win_idx = 2'(i);
    end
  end

  assign w_req_any = |req;
  assign w_win_oh  = 4'b0001 << w_win_idx;
  assign w_idle    = (state_q == S_IDLE);

  // While idle the raster is fed the winner's live fields so the first pixel is ready on entry.
  assign w_x0   = w_idle ? rect_x[w_win_idx*X_W +: X_W]    : x0_q;
  assign w_y0   = w_idle ? rect_y[w_win_idx*Y_W +: Y_W]    : y0_q;
  assign w_w_m1 = w_idle ? rect_w_m1[w_win_idx*X_W +: X_W] : w_m1_q;
  assign w_h_m1 = w_idle ? rect_h_m1[w_win_idx*Y_W +: Y_W] : h_m1_q;

  pong_rect_raster #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .clk         (clk),
    .reset       (reset),
    .load_i      (w_idle && w_req_any),
    .step_i      ((state_q == S_DRAW) && !w_last),
    .x0_i        (w_x0),
    .y0_i        (w_y0),
    .w_m1_i      (w_w_m1),
    .h_m1_i      (w_h_m1),
    .last_o      (w_last),
    .x_o         (w_px),
    .y_o         (w_py),
    .on_screen_o (w_on_screen)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_m1_q       <= '0;
      h_m1_q       <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_req_any) begin
            state_q      <= S_DRAW;
            grant_q      <= w_win_oh;
            owner_q      <= w_win_oh;
            x0_q         <= w_x0;
            y0_q         <= w_y0;
            w_m1_q       <= w_w_m1;
            h_m1_q       <= w_h_m1;
            x_out_q      <= w_px;
            y_out_q      <= w_py;
            colour_out_q <= rect_colour[w_win_idx*COLOUR_W +: COLOUR_W];
            plot_q       <= w_on_screen;
          end
        end
        S_DRAW: begin
          if (w_last) begin
            state_q      <= S_FIN;
            grant_q      <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
          end else begin
            x_out_q <= w_px;
            y_out_q <= w_py;
            plot_q  <= w_on_screen;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fcnt_d = (fcnt_q == CNT_W'(FRAME_CYCLES - 1)) ? '0 : fcnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      tick_q <= (fcnt_d == CNT_W'(FRAME_CYCLES - 1));
    end
  end

  assign grant      = grant_q;
  assign done       = (state_q == S_FIN) ? owner_q : 4'b0000;
  assign busy       = !w_idle;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_draw_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pong_draw_scheduler: scoreboard bench with a per-rectangle pixel model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pong_draw_scheduler;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int FRAME    = 10;
`ifdef PONG_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req = 4'b0;
  logic [X_W-1:0]      rx [4];
  logic [Y_W-1:0]      ry [4];
  logic [X_W-1:0]      rw [4];
  logic [Y_W-1:0]      rh [4];
  logic [COLOUR_W-1:0] rc [4];
  logic [4*X_W-1:0]      rect_x, rect_w_m1;
  logic [4*Y_W-1:0]      rect_y, rect_h_m1;
  logic [4*COLOUR_W-1:0] rect_colour;
  logic [3:0]          grant, done;
  logic                busy, plot, frame_tick;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;

  assign rect_x      = {rx[3], rx[2], rx[1], rx[0]};
  assign rect_y      = {ry[3], ry[2], ry[1], ry[0]};
  assign rect_w_m1   = {rw[3], rw[2], rw[1], rw[0]};
  assign rect_h_m1   = {rh[3], rh[2], rh[1], rh[0]};
  assign rect_colour = {rc[3], rc[2], rc[1], rc[0]};

  pong_draw_scheduler #(
    .X_W (X_W), .Y_W (Y_W), .COLOUR_W (COLOUR_W), .FRAME_CYCLES (FRAME)
  ) dut (
    .clk (clk), .reset (reset), .req (req),
    .rect_x (rect_x), .rect_y (rect_y), .rect_w_m1 (rect_w_m1),
    .rect_h_m1 (rect_h_m1), .rect_colour (rect_colour),
    .grant (grant), .done (done), .busy (busy),
    .x_out (x_out), .y_out (y_out), .colour_out (colour_out),
    .plot (plot), .frame_tick (frame_tick)
  );

  typedef struct {
    bit is_done;
    int idx;
    int x;
    int y;
    int col;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  tick_idx = 0;
  int  pix_cnt = 0;
  int  first_plot [4];
  int  last_plot [4];
  int  done_cyc [4];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every plot or done cycle consumes the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        tick_idx = 0;
      end else begin
        checks++;
        if (frame_tick !== ((tick_idx % FRAME) == FRAME - 1)) begin
          errors++;
          $display("FAIL frame_tick at cycle %0d after release: got %b, required %b",
                   tick_idx, frame_tick, (tick_idx % FRAME) == FRAME - 1);
        end
        tick_idx++;
        if (plot === 1'b1) begin
          checks++;
          pix_cnt++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL pixel: got plot at x=%0d y=%0d, required no plot", x_out, y_out);
          end else begin
            e = sb_q.pop_front();
            if (e.is_done || int'(x_out) != e.x || int'(y_out) != e.y ||
                int'(colour_out) != e.col || grant !== (4'b0001 << e.idx)) begin
              errors++;
              $display("FAIL pixel: got x=%0d y=%0d c=%0d grant=%b, required done=%0d x=%0d y=%0d c=%0d req%0d",
                       x_out, y_out, colour_out, grant, e.is_done, e.x, e.y, e.col, e.idx);
            end
            if (first_plot[e.idx] < 0) first_plot[e.idx] = cyc;
            last_plot[e.idx] = cyc;
          end
        end
        if (done !== 4'b0000) begin
          checks++;
          for (int i = 0; i < 4; i++) if (done[i]) done_cyc[i] = cyc;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL done: got %b, required no done", done);
          end else begin
            e = sb_q.pop_front();
            if (!e.is_done || done !== (4'b0001 << e.idx) || plot === 1'b1) begin
              errors++;
              $display("FAIL done: got done=%b plot=%b, required done for req%0d (event is_done=%0d)",
                       done, plot, e.idx, e.is_done);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({grant, done, busy, x_out, y_out, colour_out, plot, frame_tick} !== '0) begin
      errors++;
      $display("FAIL %s: got grant=%b done=%b busy=%b x=%0d y=%0d c=%0d plot=%b tick=%b, required all 0",
               name, grant, done, busy, x_out, y_out, colour_out, plot, frame_tick);
    end
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    rx[i] = X_W'(x);
    ry[i] = Y_W'(y);
    rw[i] = X_W'(w);
    rh[i] = Y_W'(h);
    rc[i] = COLOUR_W'(c);
  endtask

  task automatic clear_marks();
    for (int i = 0; i < 4; i++) begin
      first_plot[i] = -1;
      last_plot[i]  = -1;
      done_cyc[i]   = -1;
    end
  endtask

  // Reference model: every pixel of the rectangle row-major, then its done event.
  task automatic push_rect(input int i);
    ev_t e;
    for (int py = 0; py <= int'(rh[i]); py++) begin
      for (int px = 0; px <= int'(rw[i]); px++) begin
        int ax;
        int ay;
        ax = int'(rx[i]) + px;
        ay = int'(ry[i]) + py;
        if (!(CLIP && (ax >= 160 || ay >= 120))) begin
          e.is_done = 1'b0;
          e.idx = i;
          e.x = ax % 256;
          e.y = ay % 128;
          e.col = int'(rc[i]);
          sb_q.push_back(e);
        end
      end
    end
    e.is_done = 1'b1;
    e.idx = i;
    e.x = 0;
    e.y = 0;
    e.col = 0;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Requester side: drop each req bit at the edge on which its done is seen.
  task automatic serve(input string name, input int budget);
    int n;
    logic [3:0] d;
    n = 0;
    while (req != 4'b0000) begin
      @(negedge clk);
      #2;
      d = done;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL %s: got req=%b still pending, required all done within %0d cycles", name, req, budget);
        req = 4'b0000;
        tick(1);
      end else if (d != 4'b0000) begin
        tick(1);
        req = req & ~d;
      end
    end
  endtask

  initial begin
    int k;
    int base;
    int mask;
    for (int i = 0; i < 4; i++) set_rect(i, 0, 0, 0, 0, 0);
    clear_marks();
    tick(3);
    chk_zero("reset_state");
    reset = 1'b1;
    tick(2);

    // Single request from the left paddle
    set_rect(1, 10, 20, 3, 1, 5);
    clear_marks();
    push_rect(1);
    k = cyc;
    req = 4'b0010;
    serve("single", 100);
    chk("single_first_plot", first_plot[1], k + 1);
    chk("single_last_plot", last_plot[1], k + 8);
    chk("single_done", done_cyc[1], k + 9);

    // Clear and ball together; full-screen clear first
    set_rect(0, 0, 0, 159, 119, 2);
    set_rect(3, 50, 60, 1, 1, 7);
    clear_marks();
    push_rect(0);
    push_rect(3);
    k = cyc;
    req = 4'b1001;
    serve("priority", 25000);
    chk("prio_clear_first", first_plot[0], k + 1);
    chk("prio_clear_done", done_cyc[0], k + 1 + 19200);
    chk("prio_ball_gap", first_plot[3], last_plot[0] + 3);

    // Ball raised mid-draw; paddle fields scrambled after latch
    set_rect(1, 5, 30, 1, 7, 3);
    clear_marks();
    push_rect(1);
    k = cyc;
    req = 4'b0010;
    tick(3);
    rx[1] = 8'd100;
    ry[1] = 7'd90;
    rc[1] = 3'd6;
    set_rect(3, 80, 40, 2, 2, 1);
    push_rect(3);
    req = req | 4'b1000;
    serve("middraw", 300);
    chk("middraw_left_done", done_cyc[1], k + 17);
    chk("middraw_ball_gap", first_plot[3], last_plot[1] + 3);

    // Reset after five pixels
    set_rect(2, 20, 10, 7, 3, 4);
    clear_marks();
    push_rect(2);
    base = pix_cnt;
    req = 4'b0100;
    for (int n = 0; n < 50 && pix_cnt < base + 5; n++) begin
      @(negedge clk);
      #2;
    end
    chk("reset_mid_pixels", pix_cnt - base, 5);
    reset = 1'b0;
    #1;
    chk_zero("reset_mid_outputs");
    sb_q.delete();
    req = 4'b0000;
    tick(3);
    reset = 1'b1;
    tick(5);
    chk("reset_no_done", done_cyc[2], -1);
    set_rect(2, 30, 50, 2, 1, 6);
    clear_marks();
    push_rect(2);
    k = cyc;
    req = 4'b0100;
    serve("after_reset", 100);
    chk("after_reset_done", done_cyc[2], k + 7);

    // Corner rectangle: wraps, or clips with PONG_CLIP_EN
    set_rect(2, 158, 118, 3, 3, 6);
    clear_marks();
    push_rect(2);
    k = cyc;
    req = 4'b0100;
    serve("corner", 100);
    chk("corner_done", done_cyc[2], k + 17);

    // Random batches with mid-draw scrambling of the active requester
    for (int it = 0; it < 30; it++) begin
      mask = $urandom_range(1, 15);
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127),
                   $urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 7));
          push_rect(i);
        end
      end
      req = 4'(mask);
      tick(2);
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) begin
          rx[i] = X_W'($urandom);
          ry[i] = Y_W'($urandom);
          rc[i] = COLOUR_W'($urandom);
        end
      end
      serve("random", 2000);
    end

    tick(5);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
